// File: rtl/imm_expand_pkg.sv
// Shared types and constants for the immediate expander pipeline.
package imm_expand_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROT_W  = 5;

    typedef enum logic [1:0] {
        IMM_MODE_THUMB  = 2'b00,
        IMM_MODE_ARM    = 2'b01,
        IMM_MODE_ZEXT12 = 2'b10,
        IMM_MODE_RSVD   = 2'b11
    } imm_mode_e;

    // Decoded, not-yet-rotated beat; carry is the pass-through value used when rot==0.
    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [ROT_W-1:0]  rot;
        logic              carry;
        logic              err;
    } imm_dec_t;

endpackage

// File: rtl/imm_expand_pipe_ror32_carry.sv
// Combinational 32-bit rotate-right with shifter carry-out (amount 0 passes carry_in).
module ror32_carry
    import imm_expand_pkg::*;
(
    input  logic [DATA_W-1:0] val,
    input  logic [ROT_W-1:0]  amt,
    input  logic              carry_in,
    output logic [DATA_W-1:0] res,
    output logic              carry_out
);

    logic [2*DATA_W-1:0] dbl;

    always_comb begin
        dbl       = {val, val} >> amt;
        res       = dbl[DATA_W-1:0];
        carry_out = (amt == '0) ? carry_in : dbl[DATA_W-1];
    end

endmodule

// File: rtl/imm_expand_pipe.sv
// Pipelined Thumb/ARM/zero-extend immediate expander with valid/ready handshake.
// Define IMM_EXPAND_ARM_EN to decode ARM modified immediates; otherwise mode 01 is reserved.
module imm_expand_pipe
    import imm_expand_pkg::*;
#(
    parameter int unsigned PIPE  = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [11:0]       in_imm12,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm32,
    output logic              out_carry,
    output logic              out_err,
    output logic [TAG_W-1:0]  out_tag
);

    imm_dec_t          dec;
    imm_dec_t          fin;
    logic              fin_valid;
    logic [TAG_W-1:0]  fin_tag;
    logic              out_load;
    logic [DATA_W-1:0] rot_val;
    logic              rot_carry;

    assign out_load = !out_valid || out_ready;

    // Decode the mode into an unrotated value, rotate amount and fallback carry.
    always_comb begin
        dec       = '0;
        dec.carry = in_carry;
        case (imm_mode_e'(in_mode))
            IMM_MODE_THUMB: begin
                if (in_imm12[11:10] == 2'b00) begin
                    case (in_imm12[9:8])
                        2'b00:   dec.val = {24'b0, in_imm12[7:0]};
                        2'b01:   dec.val = {8'b0, in_imm12[7:0], 8'b0, in_imm12[7:0]};
                        2'b10:   dec.val = {in_imm12[7:0], 8'b0, in_imm12[7:0], 8'b0};
                        default: dec.val = {4{in_imm12[7:0]}};
                    endcase
                    if (in_imm12[9:8] != 2'b00 && in_imm12[7:0] == 8'h00) begin
                        dec.err = 1'b1;
                        dec.val = '0;
                    end
                end else begin
                    dec.val = {24'b0, 1'b1, in_imm12[6:0]};
                    dec.rot = in_imm12[11:7];
                end
            end
`ifdef IMM_EXPAND_ARM_EN
            IMM_MODE_ARM: begin
                dec.val = {24'b0, in_imm12[7:0]};
                dec.rot = {in_imm12[11:8], 1'b0};
            end
`else
            IMM_MODE_ARM:    dec.err = 1'b1;
`endif
            IMM_MODE_ZEXT12: dec.val = {20'b0, in_imm12};
            default:         dec.err = 1'b1;
        endcase
    end

    generate
        if (PIPE == 2) begin : g_two
            logic             s1_valid;
            imm_dec_t         s1;
            logic [TAG_W-1:0] s1_tag;
            logic             s1_moves;

            assign s1_moves  = s1_valid && out_load;
            assign in_ready  = !s1_valid || s1_moves;
            assign fin_valid = s1_valid;
            assign fin       = s1;
            assign fin_tag   = s1_tag;

            // Stage 1 holds the decoded beat until the output stage can take it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1       <= '0;
                    s1_tag   <= '0;
                end else if (in_ready) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1     <= dec;
                        s1_tag <= in_tag;
                    end
                end
            end
        end else begin : g_one
            assign in_ready  = out_load;
            assign fin_valid = in_valid;
            assign fin       = dec;
            assign fin_tag   = in_tag;
        end
    endgenerate

    ror32_carry u_ror (
        .val       (fin.val),
        .amt       (fin.rot),
        .carry_in  (fin.carry),
        .res       (rot_val),
        .carry_out (rot_carry)
    );

    // Output stage: rotate result registered; holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm32 <= '0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (out_load) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                out_imm32 <= rot_val;
                out_carry <= rot_carry;
                out_err   <= fin.err;
                out_tag   <= fin_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_expand_pipe.sv
// Directed self-checking bench for imm_expand_pipe (PIPE=2).
module tb_imm_expand_pipe;

    localparam int unsigned PIPE  = 2;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_mode = 2'b00;
    logic [11:0]      in_imm12 = 12'h000;
    logic             in_carry = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_imm32;
    logic             out_carry;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_expand_pipe #(.PIPE(PIPE), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm12  (in_imm12),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm32 (out_imm32),
        .out_carry (out_carry),
        .out_err   (out_err),
        .out_tag   (out_tag)
    );

    // Stream beat i: ZEXT12 of 0x100+i, carry i[0], tag i.
    task automatic set_beat(input int i);
        in_valid = 1'b1;
        in_mode  = 2'b10;
        in_imm12 = 12'h100 + 12'(i);
        in_carry = i[0];
        in_tag   = 4'(i);
    endtask

    // Push one beat on an empty pipe and wait (bounded) for its result, then pop it.
    task automatic send_one(input logic [1:0] mode, input logic [11:0] imm, input logic c,
                            input logic [3:0] tag, output logic v, output logic [31:0] o_imm,
                            output logic o_c, output logic o_e, output logic [3:0] o_tag,
                            output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_imm12  = imm;
        in_carry  = c;
        in_tag    = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        v     = out_valid;
        o_imm = out_imm32;
        o_c   = out_carry;
        o_e   = out_err;
        o_tag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_imm32, out_carry, out_err, out_tag} !== 39'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {out_valid, out_imm32, out_carry, out_err, out_tag});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_thumb;
        logic [11:0] imm_t [7] = '{12'h0AB, 12'h1AB, 12'h3FF, 12'h100, 12'h2CD, 12'h4FF, 12'h400};
        logic        c_t   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] e_imm [7] = '{32'h000000AB, 32'h00AB00AB, 32'hFFFFFFFF, 32'h0,
                                   32'hCD00CD00, 32'h7F800000, 32'h80000000};
        logic        e_c   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        e_e   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic v, oc, oe;
        logic [31:0] oi;
        logic [3:0] ot;
        int lat;
        for (int i = 0; i < 7; i++) begin
            send_one(2'b00, imm_t[i], c_t[i], 4'(i), v, oi, oc, oe, ot, lat);
            checks++;
            if ({v, oi, oc, oe, ot} !== {1'b1, e_imm[i], e_c[i], e_e[i], 4'(i)}) begin
                errors++;
                $display("FAIL thumb_%h got v%b %h c%b e%b t%h exp v1 %h c%b e%b t%h",
                         imm_t[i], v, oi, oc, oe, ot, e_imm[i], e_c[i], e_e[i], 4'(i));
            end
            checks++;
            if (lat !== int'(PIPE)) begin
                errors++;
                $display("FAIL thumb_latency got %0d exp %0d", lat, PIPE);
            end
        end
    endtask

    task automatic test_arm;
        logic [11:0] imm_t [4] = '{12'h4FF, 12'h0FF, 12'hF01, 12'h1FF};
        logic        c_t   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef IMM_EXPAND_ARM_EN
        logic [31:0] e_imm [4] = '{32'hFF000000, 32'h000000FF, 32'h00000004, 32'hC000003F};
        logic        e_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        e_e   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        logic [31:0] e_imm [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic        e_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        e_e   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        logic v, oc, oe;
        logic [31:0] oi;
        logic [3:0] ot;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_one(2'b01, imm_t[i], c_t[i], 4'(i + 8), v, oi, oc, oe, ot, lat);
            checks++;
            if ({v, oi, oc, oe, ot} !== {1'b1, e_imm[i], e_c[i], e_e[i], 4'(i + 8)}) begin
                errors++;
                $display("FAIL arm_%h got v%b %h c%b e%b t%h exp v1 %h c%b e%b t%h",
                         imm_t[i], v, oi, oc, oe, ot, e_imm[i], e_c[i], e_e[i], 4'(i + 8));
            end
        end
    endtask

    task automatic test_zext_rsvd;
        logic v, oc, oe;
        logic [31:0] oi;
        logic [3:0] ot;
        int lat;
        send_one(2'b10, 12'hFFF, 1'b1, 4'hC, v, oi, oc, oe, ot, lat);
        checks++;
        if ({v, oi, oc, oe, ot} !== {1'b1, 32'h00000FFF, 1'b1, 1'b0, 4'hC}) begin
            errors++;
            $display("FAIL zext_fff got v%b %h c%b e%b t%h exp v1 00000fff c1 e0 tc",
                     v, oi, oc, oe, ot);
        end
        send_one(2'b11, 12'h123, 1'b0, 4'hD, v, oi, oc, oe, ot, lat);
        checks++;
        if ({v, oi, oc, oe, ot} !== {1'b1, 32'h0, 1'b0, 1'b1, 4'hD}) begin
            errors++;
            $display("FAIL rsvd_mode got v%b %h c%b e%b t%h exp v1 00000000 c0 e1 td",
                     v, oi, oc, oe, ot);
        end
        send_one(2'b11, 12'hABC, 1'b1, 4'hE, v, oi, oc, oe, ot, lat);
        checks++;
        if ({v, oi, oc, oe, ot} !== {1'b1, 32'h0, 1'b1, 1'b1, 4'hE}) begin
            errors++;
            $display("FAIL rsvd_carry got v%b %h c%b e%b t%h exp v1 00000000 c1 e1 te",
                     v, oi, oc, oe, ot);
        end
    endtask

    task automatic test_backpressure;
        int acc = 0;
        int got = 0;
        out_ready = 1'b0;
        set_beat(0);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc < 5) set_beat(acc); else in_valid = 1'b0;
            #1;
        end
        checks++;
        if (acc !== int'(PIPE)) begin
            errors++;
            $display("FAIL bp_accepted got %0d exp %0d", acc, PIPE);
        end
        checks++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL bp_stalled got rdy%b v%b t%h exp rdy0 v1 t0", in_ready, out_valid, out_tag);
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (out_valid) begin
                checks++;
                if ({out_tag, out_imm32, out_carry, out_err} !==
                    {4'(got), 32'h100 + 32'(got), got[0], 1'b0}) begin
                    errors++;
                    $display("FAIL bp_order got t%h %h c%b e%b exp t%h %h c%b e0",
                             out_tag, out_imm32, out_carry, out_err,
                             4'(got), 32'h100 + 32'(got), got[0]);
                end
                got++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc < 5) set_beat(acc); else in_valid = 1'b0;
            #1;
        end
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL bp_count got %0d exp 5", got);
        end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int got = 0;
        int stalls = 0;
        int first = -1;
        int last = -1;
        out_ready = 1'b1;
        set_beat(0);
        #1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                checks++;
                if ({out_tag, out_imm32} !== {4'(got), 32'h100 + 32'(got)}) begin
                    errors++;
                    $display("FAIL b2b_data got t%h %h exp t%h %h",
                             out_tag, out_imm32, 4'(got), 32'h100 + 32'(got));
                end
                got++;
            end
            if (in_valid && in_ready) acc++;
            else if (in_valid) stalls++;
            @(posedge clk); #1;
            if (acc < 8) set_beat(acc); else in_valid = 1'b0;
            #1;
        end
        checks++;
        if ({got, first, last - first, stalls} !== {32'd8, 32'(PIPE), 32'd7, 32'd0}) begin
            errors++;
            $display("FAIL b2b_rate got n%0d first%0d span%0d stalls%0d exp n8 first%0d span7 stalls0",
                     got, first, last - first, stalls, PIPE);
        end
    endtask

    task automatic test_reset_midflight;
        logic v, oc, oe;
        logic [31:0] oi;
        logic [3:0] ot;
        int lat;
        out_ready = 1'b0;
        set_beat(3);
        @(posedge clk); #1;
        set_beat(4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL mid_full got v%b rdy%b t%h exp v1 rdy0 t3", out_valid, in_ready, out_tag);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_imm32, out_carry, out_err, out_tag} !== {1'b0, 1'b1, 38'h0}) begin
            errors++;
            $display("FAIL mid_reset got v%b rdy%b %h c%b e%b t%h exp v0 rdy1 0 c0 e0 t0",
                     out_valid, in_ready, out_imm32, out_carry, out_err, out_tag);
        end
        send_one(2'b10, 12'h5A5, 1'b1, 4'h9, v, oi, oc, oe, ot, lat);
        checks++;
        if ({v, oi, oc, oe, ot, 32'(lat)} !== {1'b1, 32'h000005A5, 1'b1, 1'b0, 4'h9, 32'(PIPE)}) begin
            errors++;
            $display("FAIL post_reset got v%b %h c%b e%b t%h lat%0d exp v1 000005a5 c1 e0 t9 lat%0d",
                     v, oi, oc, oe, ot, lat, PIPE);
        end
    endtask

    initial begin
        test_reset();
        test_thumb();
        test_arm();
        test_zext_rsvd();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
